alu_writeback_unit: RTL and testbench
=====================================

// Module: alu_writeback_unit
// PURPOSE
//   Writeback stage directly downstream of the 8-bit ALU. Captures result, mul_high
//   and SREG flags under a valid/ready handshake and writes them into an
//   NREGS x 8-bit register file. Masks flag updates per opcode into a persistent
//   status register. Feeds carry_flag back to the ALU carry input for ADDC/SUBC, and
//   provides two combinational read ports for operand fetch.
// PARAMETERS
//   NREGS  8  number of 8-bit registers (power of two)
//   AW     3  register address width, = log2(NREGS)
// PORTS
//   clk         in   1   clock, all state on rising edge
//   rst         in   1   synchronous, active-high reset
//   in_valid    in   1   ALU output bundle valid
//   in_ready    out  1   unit can accept a bundle this cycle
//   fsl         in   4   opcode of the bundle (ALU encoding: 0000 ADD .. 1111 COMPARE)
//   rd          in   AW  destination register
//   result      in   8   ALU result (low byte for MULTIPLY)
//   mul_high    in   8   ALU high product byte (used only when fsl==1110)
//   sreg_in     in   4   ALU flags {V,S,C,Z} = bits [3],[2],[1],[0]
//   rs1_addr    in   AW  read port 1 address
//   rs1_data    out  8   rf[rs1_addr]
//   rs2_addr    in   AW  read port 2 address
//   rs2_data    out  8   rf[rs2_addr]
//   sreg        out  4   committed status register {V,S,C,Z}
//   carry_flag  out  1   = sreg[1]; drives ALU carry-in
//   wb_done     out  1   one-cycle pulse when a bundle's writeback is complete
// BEHAVIOUR
//   Reset: rf all 0, sreg=0, state=IDLE, wb_done=0. in_ready=1 in the cycle after
//     rst deasserts. rst asserted in HI aborts the pending high-byte write.
//   Accept = in_valid & in_ready. in_ready = (state==IDLE). Bundles presented while
//     in_ready=0 are ignored; upstream holds them.
//   FSM IDLE: on accept:
//     - fsl!=1111: rf[rd] <= result.
//     - update sreg per mask.
//     - fsl==1110: latch mul_high and hi_addr=(rd+1) mod NREGS; go to HI, no wb_done.
//     - otherwise: wb_done=1 next cycle, stay in IDLE.
//   FSM HI: rf[hi_addr] <= latched mul_high; wb_done=1 next cycle; return to IDLE.
//     Multiply occupancy is 2 cycles. Wrap: rd=NREGS-1 writes the high byte to r0.
//   Flag masks (1=take sreg_in bit, 0=hold sreg bit), order V S C Z:
//     00xx add/sub/addc/subc  1111
//     01xx logic              0101
//     10xx shifts             0111
//     110x rotates            0101
//     1110 multiply           0101
//     1111 compare            0101, and no rf write
//   Latency: rf and sreg update at the accept edge. Read ports are combinational
//     from rf, so a read of rd shows new data one cycle after accept.
//   carry_flag changes only at an accept edge for 00xx or 10xx ops, or on reset.
// CONFIGURATION
//   WB_FORWARD_EN defined: a read port whose address matches the write in progress
//     this cycle returns the write data. Write in progress = accept with rd, or HI
//     state with hi_addr. carry_flag likewise forwards the incoming masked C.
//   WB_FORWARD_EN undefined: read ports and carry_flag reflect registered state only.
// TESTING
//   1 reset, ADD bundle rd=2 result=0x5A sreg_in=0110 -> r2=0x5A next cycle,
//     sreg=0110, carry_flag=1, wb_done pulse.
//   2 MULTIPLY rd=7 result=0x10 mul_high=0xA5 -> r7=0x10, in_ready=0 one cycle,
//     then r0=0xA5, wb_done once.
//   3 sreg=0010 (C=1), then XOR bundle sreg_in=0101 -> sreg=0111; C held at 1.
//   4 COMPARE rd=3 result=0x01 sreg_in=1111 with r3=0x77 -> r3 stays 0x77,
//     sreg={V,1,C,1} with V/C held.
//   5 in_valid held high across multiply HI cycle -> second bundle accepted only
//     when in_ready returns; rst in HI -> r(rd+1) unchanged, all rf=0.
//   6 rs1_addr=4 with ADD rd=4 result=0x33 accepted this cycle -> rs1_data=0x33 same
//     cycle with WB_FORWARD_EN, old r4 without it.

Source files
------------

// File: rtl/alu_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_writeback_unit
// Description : Writeback stage behind the 8-bit ALU. Accepts a result bundle
//               under valid/ready, writes an NREGS x 8 register file, merges
//               masked flags into a persistent status register, and serves two
//               combinational read ports. A MULTIPLY occupies two cycles: the
//               low byte goes to rd, and then the high byte goes to rd+1, which
//               wraps to r0 when rd is the last register.
// Options     : WB_FORWARD_EN - when defined, the read ports and carry_flag
//               return the value being written in the current cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_writeback_unit #(
  parameter int NREGS = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    fsl,
  input  logic [AW-1:0] rd,
  input  logic [7:0]    result,
  input  logic [7:0]    mul_high,
  input  logic [3:0]    sreg_in,
  input  logic [AW-1:0] rs1_addr,
  output logic [7:0]    rs1_data,
  input  logic [AW-1:0] rs2_addr,
  output logic [7:0]    rs2_data,
  output logic [3:0]    sreg,
  output logic          carry_flag,
  output logic          wb_done
);

  localparam logic [3:0] OP_MUL = 4'b1110;
  localparam logic [3:0] OP_CMP = 4'b1111;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HI   = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    rf_q [NREGS];
  logic [7:0]    rf_d [NREGS];
  logic [3:0]    sreg_q, sreg_d;
  logic [7:0]    hi_data_q, hi_data_d;
  logic [AW-1:0] hi_addr_q, hi_addr_d;
  logic          wb_done_q, wb_done_d;

  logic          accept;
  logic [3:0]    flag_mask;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;

  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid & in_ready;

  // Flag mask per opcode, ordered {V,S,C,Z}: 1 takes the ALU flag, 0 holds it.
  always_comb begin
    flag_mask = 4'b0101;
    casez (fsl)
      4'b00??: flag_mask = 4'b1111;
      4'b01??: flag_mask = 4'b0101;
      4'b10??: flag_mask = 4'b0111;
      default: flag_mask = 4'b0101;
    endcase
  end

  // Select the single register-file write for this cycle, plus the next state.
  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    hi_data_d = hi_data_q;
    hi_addr_d = hi_addr_q;
    wb_done_d = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = rd;
    wr_data   = result;
    case (state_q)
      IDLE: begin
        if (accept) begin
          wr_en  = (fsl != OP_CMP);
          sreg_d = (sreg_q & ~flag_mask) | (sreg_in & flag_mask);
          if (fsl == OP_MUL) begin
            hi_data_d = mul_high;
            hi_addr_d = rd + AW'(1);
            state_d   = HI;
          end else begin
            wb_done_d = 1'b1;
          end
        end
      end
      HI: begin
        wr_en     = 1'b1;
        wr_addr   = hi_addr_q;
        wr_data   = hi_data_q;
        wb_done_d = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Apply the selected write to a copy of the register file.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      rf_d[i] = rf_q[i];
    end
    if (wr_en) begin
      rf_d[wr_addr] = wr_data;
    end
  end

  // State registers. A reset also discards a pending high-byte write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sreg_q    <= 4'b0000;
      hi_data_q <= 8'h00;
      hi_addr_q <= '0;
      wb_done_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= 8'h00;
      end
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      hi_data_q <= hi_data_d;
      hi_addr_q <= hi_addr_d;
      wb_done_q <= wb_done_d;
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

  assign sreg    = sreg_q;
  assign wb_done = wb_done_q;

`ifdef WB_FORWARD_EN
  // Read ports bypass the write in progress so that operand fetch sees it at once.
  always_comb begin
    rs1_data = (wr_en && (wr_addr == rs1_addr)) ? wr_data : rf_q[rs1_addr];
    rs2_data = (wr_en && (wr_addr == rs2_addr)) ? wr_data : rf_q[rs2_addr];
  end
  assign carry_flag = sreg_d[1];
`else
  // Read ports return registered contents only.
  always_comb begin
    rs1_data = rf_q[rs1_addr];
    rs2_data = rf_q[rs2_addr];
  end
  assign carry_flag = sreg_q[1];
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_writeback_unit
// Description : Directed self-checking bench for alu_writeback_unit.
//               It follows WB_FORWARD_EN when the macro is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_writeback_unit;

`ifdef WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] fsl;
  logic [2:0] rd;
  logic [7:0] result;
  logic [7:0] mul_high;
  logic [3:0] sreg_in;
  logic [2:0] rs1_addr;
  logic [7:0] rs1_data;
  logic [2:0] rs2_addr;
  logic [7:0] rs2_data;
  logic [3:0] sreg;
  logic       carry_flag;
  logic       wb_done;

  int tests = 0;
  int fails = 0;

  alu_writeback_unit #(.NREGS(8), .AW(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .fsl        (fsl),
    .rd         (rd),
    .result     (result),
    .mul_high   (mul_high),
    .sreg_in    (sreg_in),
    .rs1_addr   (rs1_addr),
    .rs1_data   (rs1_data),
    .rs2_addr   (rs2_addr),
    .rs2_data   (rs2_data),
    .sreg       (sreg),
    .carry_flag (carry_flag),
    .wb_done    (wb_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: step just past the rising edge so that outputs are stable.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rf_chk(input string tag, input logic [2:0] a, input logic [7:0] exp);
    rs1_addr = a;
    #1;
    chk(tag, rs1_data, exp);
  endtask

  task automatic drive(input logic [3:0] f, input logic [2:0] r, input logic [7:0] res,
                       input logic [7:0] mh, input logic [3:0] fl);
    in_valid = 1'b1;
    fsl      = f;
    rd       = r;
    result   = res;
    mul_high = mh;
    sreg_in  = fl;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; fsl = 4'h0; rd = 3'd0; result = 8'h00;
    mul_high = 8'h00; sreg_in = 4'h0; rs1_addr = 3'd0; rs2_addr = 3'd0;
    cyc(); cyc();
    rst = 1'b0;
    #1;
    // Reset state
    chk("rst_ready", {7'd0, in_ready}, 8'h01);
    chk("rst_sreg", {4'd0, sreg}, 8'h00);
    chk("rst_carry", {7'd0, carry_flag}, 8'h00);
    chk("rst_done", {7'd0, wb_done}, 8'h00);
    rf_chk("rst_r2", 3'd2, 8'h00);

    // 1: ADD rd=2 result=0x5A, flags 0110
    drive(4'b0000, 3'd2, 8'h5A, 8'h00, 4'b0110);
    cyc(); in_valid = 1'b0;
    rf_chk("add_r2", 3'd2, 8'h5A);
    chk("add_sreg", {4'd0, sreg}, 8'h06);
    chk("add_carry", {7'd0, carry_flag}, 8'h01);
    chk("add_done", {7'd0, wb_done}, 8'h01);
    cyc();
    chk("add_done_clr", {7'd0, wb_done}, 8'h00);

    // 2: MULTIPLY rd=7 wraps the high byte into r0; S,Z taken -> 0010
    drive(4'b1110, 3'd7, 8'h10, 8'hA5, 4'b0000);
    cyc(); in_valid = 1'b0;
    rf_chk("mul_r7", 3'd7, 8'h10);
    chk("mul_busy", {7'd0, in_ready}, 8'h00);
    chk("mul_done_lo", {7'd0, wb_done}, 8'h00);
    chk("mul_sreg", {4'd0, sreg}, 8'h02);
    rf_chk("mul_r0_pend", 3'd0, FWD ? 8'hA5 : 8'h00);
    cyc();
    rf_chk("mul_r0", 3'd0, 8'hA5);
    chk("mul_ready", {7'd0, in_ready}, 8'h01);
    chk("mul_done", {7'd0, wb_done}, 8'h01);
    cyc();
    chk("mul_done_clr", {7'd0, wb_done}, 8'h00);

    // 3: XOR with flags 0101 on sreg=0010 -> 0111, carry held
    drive(4'b0100, 3'd5, 8'h3C, 8'h00, 4'b0101);
    cyc(); in_valid = 1'b0;
    rf_chk("xor_r5", 3'd5, 8'h3C);
    chk("xor_sreg", {4'd0, sreg}, 8'h07);
    chk("xor_carry", {7'd0, carry_flag}, 8'h01);

    // 4: r3=0x77 with sreg=1000, then COMPARE flags 1111 -> 1101, no write
    drive(4'b0000, 3'd3, 8'h77, 8'h00, 4'b1000);
    cyc(); in_valid = 1'b0;
    chk("pre_cmp_sreg", {4'd0, sreg}, 8'h08);
    drive(4'b1111, 3'd3, 8'h01, 8'h00, 4'b1111);
    cyc(); in_valid = 1'b0;
    rf_chk("cmp_r3", 3'd3, 8'h77);
    chk("cmp_sreg", {4'd0, sreg}, 8'h0D);
    chk("cmp_carry", {7'd0, carry_flag}, 8'h00);
    chk("cmp_done", {7'd0, wb_done}, 8'h01);

    // Shift takes C: 1101 with 0010 under mask 0111 -> 1010
    drive(4'b1000, 3'd1, 8'h44, 8'h00, 4'b0010);
    cyc(); in_valid = 1'b0;
    chk("shf_sreg", {4'd0, sreg}, 8'h0A);
    chk("shf_carry", {7'd0, carry_flag}, 8'h01);
    // Rotate holds C: flags 0000 under mask 0101 -> 1010
    drive(4'b1100, 3'd1, 8'h88, 8'h00, 4'b0000);
    cyc(); in_valid = 1'b0;
    chk("rot_sreg", {4'd0, sreg}, 8'h0A);
    chk("rot_carry", {7'd0, carry_flag}, 8'h01);
    rf_chk("rot_r1", 3'd1, 8'h88);
    // ADDC takes all flags
    drive(4'b0010, 3'd1, 8'h80, 8'h00, 4'b0001);
    cyc(); in_valid = 1'b0;
    chk("addc_sreg", {4'd0, sreg}, 8'h01);
    chk("addc_carry", {7'd0, carry_flag}, 8'h00);

    // 5: in_valid held high through the multiply HI cycle
    drive(4'b1110, 3'd3, 8'h11, 8'h22, 4'b0000);
    cyc();
    drive(4'b0000, 3'd6, 8'h66, 8'h00, 4'b0000);
    #1;
    chk("hold_busy", {7'd0, in_ready}, 8'h00);
    cyc();
    chk("hold_hi_done", {7'd0, wb_done}, 8'h01);
    chk("hold_ready", {7'd0, in_ready}, 8'h01);
    rf_chk("hold_r4", 3'd4, 8'h22);
    cyc(); in_valid = 1'b0;
    rf_chk("hold_r6", 3'd6, 8'h66);
    rf_chk("hold_r3", 3'd3, 8'h11);
    chk("hold_add_done", {7'd0, wb_done}, 8'h01);

    // Reset during HI discards the high byte and clears the file
    drive(4'b1110, 3'd4, 8'h44, 8'h55, 4'b0000);
    cyc(); in_valid = 1'b0;
    rst = 1'b1;
    cyc();
    for (int i = 0; i < 8; i++) begin
      rs1_addr = 3'(i);
      #0.5;
      chk($sformatf("rst_hi_r%0d", i), rs1_data, 8'h00);
    end
    chk("rst_hi_sreg", {4'd0, sreg}, 8'h00);
    chk("rst_hi_done", {7'd0, wb_done}, 8'h00);
    cyc();
    rst = 1'b0;
    cyc();
    chk("rst_hi_ready", {7'd0, in_ready}, 8'h01);
    rf_chk("rst_hi_r5", 3'd5, 8'h00);

    // 6: same-cycle read of a register being written
    drive(4'b0000, 3'd4, 8'h12, 8'h00, 4'b0000);
    cyc(); in_valid = 1'b0;
    rs2_addr = 3'd2;
    drive(4'b0000, 3'd4, 8'h33, 8'h00, 4'b0010);
    rs1_addr = 3'd4;
    #1;
    chk("fwd_rs1", rs1_data, FWD ? 8'h33 : 8'h12);
    chk("fwd_rs2", rs2_data, 8'h00);
    chk("fwd_carry", {7'd0, carry_flag}, FWD ? 8'h01 : 8'h00);
    cyc(); in_valid = 1'b0;
    rf_chk("fwd_r4", 3'd4, 8'h33);
    chk("fwd_carry_q", {7'd0, carry_flag}, 8'h01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
